alu_spi_scheduler: RTL
======================

Name: alu_spi_scheduler

Overview:
SPI master that shares the serial ALU between NumRequesters requesters, for example fetch/decode and execute ports of the mini serial processor.
- Arbitrates round-robin among pending requests and latches the winner's AluPacket.
- Serialises the packet to the ALU slave, waits for the result-ready signal and deserialises the REGISTER_SIZE result.
- Returns the result to the granted requester, with a timeout guard against a silent slave.

Parameters:
NumRequesters, 2, number of requester ports (1..8)
NssPosition, 0, bit of spi.nss that selects the ALU slave
NumSlaves, 1, width of spi.nss
TimeoutCycles, 64, maximum WAIT_RESULT cycles before abort

Ports:
i_clock  input  1  system clock; SPI bits advance one per i_clock
i_reset  input  1  asynchronous, active-low reset
i_req_valid  input  NumRequesters  per-requester request pending; held until ready
i_req_packet  input  NumRequesters x $bits(AluPacket)  per-requester {op_2, op_1, op_code}
o_req_ready  output  NumRequesters  one-hot accept pulse, asserted only in IDLE
o_rsp_valid  output  NumRequesters  one-hot, 1-cycle response pulse to the granted requester
o_rsp_result  output  REGISTER_SIZE  result, valid while any o_rsp_valid is high
o_rsp_error  output  1  timeout flag, qualified by o_rsp_valid
spi  Spi.MasterSpi  -  drives nss[NumSlaves] and mosi; samples miso

Behaviour:
- P = $bits(AluPacket), R = REGISTER_SIZE.
- All outputs are registered.
- Reset (asynchronous, any state, including mid-transfer):
  - state IDLE, all counters 0, rr pointer 0.
  - nss all ones, mosi 0.
  - o_req_ready 0, o_rsp_valid 0, o_rsp_result 0, o_rsp_error 0.
- nss bits other than NssPosition are always 1.
- States: IDLE, START, SHIFT_OUT, WAIT_RESULT, SHIFT_IN, DONE.
- IDLE:
  - nss high, mosi 0.
  - If any i_req_valid is set: pick the winner by round-robin starting at the pointer, pulse o_req_ready[winner], latch packet and grant index, then go to START.
  - Pointer becomes (winner+1) mod NumRequesters.
  - If none is valid, stay in IDLE.
- START (1 cycle): nss[NssPosition]=0, mosi=1 (start bit).
- SHIFT_OUT (P cycles):
  - mosi = packet[bit_cnt], LSB first; bit_cnt counts 0..P-1.
  - At P-1, go to WAIT_RESULT and clear bit_cnt.
- WAIT_RESULT:
  - nss low, mosi=0, wait_cnt increments.
  - miso==1 moves to SHIFT_IN on the next edge (this is the slave's ready-to-send marker).
  - wait_cnt==TimeoutCycles-1 with miso still 0 moves to DONE with error=1 and result 0.
  - With a compliant slave, miso rises on the 2nd WAIT_RESULT cycle.
- SHIFT_IN (R cycles):
  - result[bit_cnt] <= miso, LSB first.
  - At R-1, go to DONE.
- DONE (1 cycle):
  - nss high.
  - o_rsp_valid[grant]=1 with o_rsp_result and o_rsp_error.
  - Return to IDLE; a new accept is possible the following cycle.
- Latency: accept in cycle t gives o_rsp_valid in cycle t+P+R+4 exactly, when the slave is compliant.
- Throughput: one transaction per P+R+5 cycles.
- Requests arriving or dropped outside IDLE are ignored; valid dropped before ready means no transaction.
- Responses have no back-pressure; the requester must capture the result in the DONE cycle.
- A timeout does not resynchronise the slave; recovery requires reset, and the error is reported only to the requester.
- With NumRequesters=1, grant is always 0.

Decomposition:
- Isa package: reuse AluPacket, Operation and REGISTER_SIZE; add ALU_PACKET_BITS = $bits(AluPacket).
- Scheduler state enum stays local to the module.
- One sub-module, round_robin_arbiter:
  - parameter N.
  - inputs: request vector, pointer.
  - outputs: one-hot grant and grant index (combinational).

Test Plan:
- Single ADD: requester 0 sends op_1=8'h0F, op_2=8'h01 (R=8) -> o_rsp_valid[0] at accept+P+12, result 8'h10, error 0; mosi shows the start bit then packet bits LSB first.
- Overflow and logic ops: ADD 8'hFF+8'h01 -> 8'h00; AND 8'hF0,8'h3C -> 8'h30; OR 8'hF0,8'h0F -> 8'hFF.
- Contention: both requesters hold valid from reset -> grants alternate 0,1,0,1; each response goes only to its grant; nss is high for exactly the DONE and IDLE cycles between transfers.
- Timeout: slave model holds miso=0 -> o_rsp_valid with error=1, result 0, after TimeoutCycles WAIT_RESULT cycles; nss goes high.
- Reset mid-SHIFT_OUT: assert i_reset at bit 3 -> nss all ones and mosi 0 immediately; no rsp_valid; the next request after release completes correctly.
- Unselected nss bits: NumSlaves=3, NssPosition=1 -> nss[0] and nss[2] stay 1 throughout.

Source files
------------

// File: rtl/alu_spi_scheduler_pkg.sv
// Shared ALU packet format, operation codes and register width for the serial ALU and its SPI scheduler.
package alu_spi_scheduler_pkg;

  localparam int REGISTER_SIZE = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } Operation;

  // op_code sits in the LSBs, so an LSB-first stream carries the opcode first
  typedef struct packed {
    logic [REGISTER_SIZE-1:0] op_2;
    logic [REGISTER_SIZE-1:0] op_1;
    Operation                 op_code;
  } AluPacket;

  localparam int ALU_PACKET_BITS = $bits(AluPacket);

  function automatic AluPacket make_packet(input Operation op,
                                           input logic [REGISTER_SIZE-1:0] a,
                                           input logic [REGISTER_SIZE-1:0] b);
    AluPacket p;
    p.op_2    = b;
    p.op_1    = a;
    p.op_code = op;
    return p;
  endfunction

endpackage

// File: rtl/alu_spi_scheduler_spi.sv
// SPI bus bundle: active-low slave selects, master-out and master-in data lines.
interface Spi #(
  parameter int NumSlaves = 1
);
  logic [NumSlaves-1:0] nss;
  logic                 mosi;
  logic                 miso;

  modport MasterSpi (output nss, output mosi, input miso);
  modport SlaveSpi  (input nss, input mosi, output miso);
endinterface

// File: rtl/alu_spi_scheduler_arbiter.sv
// Round-robin arbiter: first set request at or after ptr_i wins; purely combinational, no state.
module round_robin_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]                      req_i,
  input  logic [(N > 1 ? $clog2(N) : 1)-1:0] ptr_i,
  output logic [N-1:0]                      gnt_o,
  output logic [(N > 1 ? $clog2(N) : 1)-1:0] gnt_idx_o
);

  localparam int IdxW = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    logic            found;
    logic [IdxW-1:0] idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IdxW'((int'(ptr_i) + i) % N);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_spi_scheduler.sv
// SPI master sharing one serial ALU among requesters: accept in IDLE cycle t, response pulse at t+P+R+4.
// Requests are only accepted in IDLE; responses have no back-pressure and last exactly one cycle.
module alu_spi_scheduler
  import alu_spi_scheduler_pkg::*;
#(
  parameter int NumRequesters = 2,
  parameter int NssPosition   = 0,
  parameter int NumSlaves     = 1,
  parameter int TimeoutCycles = 64
) (
  input  logic                                            i_clock,
  input  logic                                            i_reset,
  input  logic [NumRequesters-1:0]                        i_req_valid,
  input  logic [NumRequesters-1:0][ALU_PACKET_BITS-1:0]   i_req_packet,
  output logic [NumRequesters-1:0]                        o_req_ready,
  output logic [NumRequesters-1:0]                        o_rsp_valid,
  output logic [REGISTER_SIZE-1:0]                        o_rsp_result,
  output logic                                            o_rsp_error,
  Spi.MasterSpi                                           spi
);

  localparam int P     = ALU_PACKET_BITS;
  localparam int R     = REGISTER_SIZE;
  localparam int CntW  = $clog2(((P > R) ? P : R) + 1);
  localparam int WaitW = $clog2(TimeoutCycles + 1);
  localparam int IdxW  = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT_OUT,
    S_WAIT_RESULT,
    S_SHIFT_IN,
    S_DONE
  } state_e;

  state_e                   state_q;
  logic [P-1:0]             pkt_q;
  logic [R-1:0]             res_q;
  logic [CntW-1:0]          bit_cnt_q;
  logic [WaitW-1:0]         wait_cnt_q;
  logic [IdxW-1:0]          rr_ptr_q;
  logic [IdxW-1:0]          grant_q;
  logic                     sel_q;
  logic                     mosi_q;
  logic [NumRequesters-1:0] rsp_valid_q;
  logic [R-1:0]             rsp_result_q;
  logic                     rsp_error_q;

  logic [NumRequesters-1:0] arb_gnt;
  logic [IdxW-1:0]          arb_idx;

  round_robin_arbiter #(.N(NumRequesters)) u_arb (
    .req_i     (i_req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  function automatic logic [IdxW-1:0] next_ptr(input logic [IdxW-1:0] idx);
    if (idx == IdxW'(NumRequesters - 1)) return '0;
    else return idx + 1'b1;
  endfunction

  // Ready is the arbiter decode qualified by the registered IDLE state, so the accept lands in the IDLE cycle itself.
  assign o_req_ready  = (state_q == S_IDLE && i_reset) ? arb_gnt : '0;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_error  = rsp_error_q;
  assign spi.nss      = ~(NumSlaves'(sel_q) << NssPosition);
  assign spi.mosi     = mosi_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      pkt_q        <= '0;
      res_q        <= '0;
      bit_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      sel_q        <= 1'b0;
      mosi_q       <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|i_req_valid) begin
            pkt_q    <= i_req_packet[arb_idx];
            grant_q  <= arb_idx;
            rr_ptr_q <= next_ptr(arb_idx);
            sel_q    <= 1'b1;
            mosi_q   <= 1'b1;
            state_q  <= S_START;
          end
        end
        S_START: begin
          mosi_q    <= pkt_q[0];
          pkt_q     <= pkt_q >> 1;
          bit_cnt_q <= '0;
          state_q   <= S_SHIFT_OUT;
        end
        S_SHIFT_OUT: begin
          if (bit_cnt_q == CntW'(P - 1)) begin
            mosi_q     <= 1'b0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            state_q    <= S_WAIT_RESULT;
          end else begin
            mosi_q    <= pkt_q[0];
            pkt_q     <= pkt_q >> 1;
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        S_WAIT_RESULT: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          if (spi.miso) begin
            bit_cnt_q <= '0;
            state_q   <= S_SHIFT_IN;
          end else if (wait_cnt_q == WaitW'(TimeoutCycles - 1)) begin
            sel_q        <= 1'b0;
            rsp_valid_q  <= NumRequesters'(1) << grant_q;
            rsp_result_q <= '0;
            rsp_error_q  <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_SHIFT_IN: begin
          res_q     <= {spi.miso, res_q[R-1:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == CntW'(R - 1)) begin
            sel_q        <= 1'b0;
            rsp_valid_q  <= NumRequesters'(1) << grant_q;
            rsp_result_q <= {spi.miso, res_q[R-1:1]};
            rsp_error_q  <= 1'b0;
            state_q      <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
